// File: rtl/clear_pkg.sv
// Shared types and default dimensions for the raster clear sequencer.
package clear_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } clear_state_e;

  localparam int CLEAR_X_MAX_DEF = 160;
  localparam int CLEAR_Y_MAX_DEF = 120;
  localparam int CLEAR_CNT_W     = 8;

endpackage

// File: rtl/clear.sv
// Raster clear sequencer: walks every (X,Y) pixel once per pass, then flags finished.
//  state | meaning
//  IDLE  | counters parked at (0,0), waiting for enable
//  SCAN  | counters advance one pixel per clock in raster order
//  DONE  | pass complete, finished held until enable drops
module clear
  import clear_pkg::*;
#(
  parameter int X_MAX = CLEAR_X_MAX_DEF,
  parameter int Y_MAX = CLEAR_Y_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic [CLEAR_CNT_W-1:0] CounterX,
  output logic [CLEAR_CNT_W-1:0] CounterY,
  output logic                   finished
);

  localparam logic [CLEAR_CNT_W-1:0] X_LAST = CLEAR_CNT_W'(X_MAX - 1);
  localparam logic [CLEAR_CNT_W-1:0] Y_LAST = CLEAR_CNT_W'(Y_MAX - 1);

  clear_state_e           state_q;
  logic [CLEAR_CNT_W-1:0] x_q;
  logic [CLEAR_CNT_W-1:0] y_q;
  logic                   finished_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      finished_q <= 1'b0;
    end else if (!enable) begin
      // dropping enable aborts any pass; nothing is remembered for a resume
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      finished_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= SCAN;
          x_q        <= '0;
          y_q        <= '0;
          finished_q <= 1'b0;
        end
        SCAN: begin
          if (x_q == X_LAST) begin
            x_q <= '0;
            if (y_q == Y_LAST) begin
              state_q    <= DONE;
              y_q        <= '0;
              finished_q <= 1'b1;
            end else begin
              y_q <= y_q + 1'b1;
            end
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        DONE: begin
          state_q    <= DONE;
          x_q        <= '0;
          y_q        <= '0;
          finished_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          x_q        <= '0;
          y_q        <= '0;
          finished_q <= 1'b0;
        end
      endcase
    end
  end

  assign CounterX = x_q;
  assign CounterY = y_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_clear.sv
// Scoreboard bench for clear: default 160x120 geometry plus 4x2 and 1x1 instances.
module tb_clear;

  typedef struct {
    int st;   // 0 idle, 1 scanning, 2 done
    int idx;  // linear pixel index while scanning
  } mdl_t;

  typedef struct {
    int x;
    int y;
    int fin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       en_b = 1'b0;
  logic       en_s = 1'b0;
  logic [7:0] cx_b, cy_b, cx_s, cy_s, cx_o, cy_o;
  logic       fin_b, fin_s, fin_o;

  int n_tests = 0;
  int n_fail  = 0;

  mdl_t m_b = '{0, 0};
  mdl_t m_s = '{0, 0};
  mdl_t m_o = '{0, 0};
  exp_t q_b[$];
  exp_t q_s[$];
  exp_t q_o[$];

  always #5 clk = ~clk;

  clear dut_big (
    .clk(clk), .reset(rst_b), .enable(en_b),
    .CounterX(cx_b), .CounterY(cy_b), .finished(fin_b)
  );

  clear #(.X_MAX(4), .Y_MAX(2)) dut_small (
    .clk(clk), .reset(rst_b), .enable(en_s),
    .CounterX(cx_s), .CounterY(cy_s), .finished(fin_s)
  );

  clear #(.X_MAX(1), .Y_MAX(1)) dut_one (
    .clk(clk), .reset(rst_b), .enable(en_s),
    .CounterX(cx_o), .CounterY(cy_o), .finished(fin_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mnext(mdl_t m, logic rst, logic en, int npix);
    mdl_t r;
    r = m;
    if (!rst || !en) begin
      r.st = 0;
      r.idx = 0;
    end else if (m.st == 0) begin
      r.st = 1;
      r.idx = 0;
    end else if (m.st == 1) begin
      if (m.idx == npix - 1) begin
        r.st = 2;
        r.idx = 0;
      end else begin
        r.idx = m.idx + 1;
      end
    end
    return r;
  endfunction

  function automatic exp_t mexp(mdl_t m, int xmax);
    exp_t e;
    e.x   = (m.st == 1) ? (m.idx % xmax) : 0;
    e.y   = (m.st == 1) ? (m.idx / xmax) : 0;
    e.fin = (m.st == 2) ? 1 : 0;
    return e;
  endfunction

  // Drive one clock of stimulus and queue what each DUT must show after the edge.
  task automatic step(input logic eb, input logic es);
    #1;
    en_b = eb;
    en_s = es;
    m_b = mnext(m_b, rst_b, eb, 160 * 120);
    m_s = mnext(m_s, rst_b, es, 4 * 2);
    m_o = mnext(m_o, rst_b, es, 1);
    q_b.push_back(mexp(m_b, 160));
    q_s.push_back(mexp(m_s, 4));
    q_o.push_back(mexp(m_o, 1));
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("big_x", int'(cx_b), e.x);
      chk("big_y", int'(cy_b), e.y);
      chk("big_fin", int'(fin_b), e.fin);
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      chk("small_x", int'(cx_s), e.x);
      chk("small_y", int'(cy_s), e.y);
      chk("small_fin", int'(fin_s), e.fin);
    end
    if (q_o.size() > 0) begin
      e = q_o.pop_front();
      chk("one_x", int'(cx_o), e.x);
      chk("one_y", int'(cy_o), e.y);
      chk("one_fin", int'(fin_o), e.fin);
    end
  end

  initial begin
    int first_b, first_s, first_o;

    // reset held with enable high: no scanning anywhere
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    @(negedge clk);
    #2 rst_b = 1'b1;

    // small geometries: 4x2 raster and the 1x1 corner case
    step(1'b0, 1'b0);
    first_s = -1;
    first_o = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1);
      #1;
      if (fin_s && first_s < 0) first_s = i;
      if (fin_o && first_o < 0) first_o = i;
    end
    chk("small_latency", first_s, 8);
    chk("one_latency", first_o, 1);
    step(1'b0, 1'b0);

    // full default pass, then hold in DONE
    first_b = -1;
    for (int i = 0; i < 20000; i++) begin
      step(1'b1, 1'b0);
      #1;
      if (fin_b && first_b < 0) first_b = i;
    end
    chk("big_latency", first_b, 19200);

    // no auto-restart: drop enable, then re-enable starts from (0,0)
    step(1'b0, 1'b0);
    for (int i = 0; i < 20000 && !(m_b.st == 1 && m_b.idx == 42 * 160 + 37); i++)
      step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // asynchronous reset mid-scan at (10,3)
    for (int i = 0; i < 20000 && !(m_b.st == 1 && m_b.idx == 3 * 160 + 10); i++)
      step(1'b1, 1'b0);
    @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    chk("async_rst_x", int'(cx_b), 0);
    chk("async_rst_y", int'(cy_b), 0);
    chk("async_rst_fin", int'(fin_b), 0);
    m_b = '{0, 0};
    m_s = '{0, 0};
    m_o = '{0, 0};
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    #2 rst_b = 1'b1;

    first_b = -1;
    for (int i = 0; i < 19300; i++) begin
      step(1'b1, 1'b0);
      #1;
      if (fin_b && first_b < 0) first_b = i;
    end
    chk("big_latency_after_rst", first_b, 19200);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clear.md
CLEAR -- requirements
Module: clear

Interface
REQ-001 The module SHALL have parameter X_MAX, default 160, meaning the number of columns scanned; legal range is 1..256.
REQ-002 The module SHALL have parameter Y_MAX, default 120, meaning the number of rows scanned; legal range is 1..256.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port enable, input, 1 bit: level request to run (high) or abort/idle (low) a clear pass.
REQ-006 The module SHALL have port CounterX, output, 8 bits: the current pixel column, registered.
REQ-007 The module SHALL have port CounterY, output, 8 bits: the current pixel row, registered.
REQ-008 The module SHALL have port finished, output, 1 bit: registered flag indicating that a full pass is complete.

Function
REQ-009 The block SHALL implement an FSM with exactly three states: IDLE, SCAN and DONE.
REQ-010 In IDLE, CounterX and CounterY SHALL be 0, finished SHALL be 0, and a rising edge with enable=1 SHALL move the FSM to SCAN with the counters still at (0,0).
REQ-011 In SCAN, each rising edge with enable=1 SHALL advance the counters in raster order: X increments; when X=X_MAX-1, X wraps to 0 and Y increments.
REQ-012 In SCAN with the counters at (X_MAX-1, Y_MAX-1) and enable=1, the next edge SHALL enter DONE, set the counters to (0,0) and set finished to 1.
REQ-013 Each (X,Y) pair in 0..X_MAX-1 by 0..Y_MAX-1 SHALL appear on CounterX/CounterY for exactly one clock per pass, in raster order.
REQ-014 In DONE, finished SHALL stay 1 and the counters SHALL hold at (0,0) for as long as enable=1; the block SHALL NOT restart a pass automatically.
REQ-015 enable=0 sampled in any state SHALL return the FSM to IDLE on that edge, with counters at (0,0) and finished at 0; a pass interrupted mid-scan SHALL be aborted, not paused.
REQ-016 A new pass SHALL require enable to be sampled 0 and then 1 again after DONE.
REQ-017 Counter arithmetic SHALL be 8-bit unsigned, and the counters SHALL never exceed X_MAX-1 or Y_MAX-1.
REQ-018 Latency: the first edge sampling enable=1 from IDLE enters SCAN, and finished SHALL rise on the (X_MAX*Y_MAX)-th edge after that, i.e. edge 19200 with the default parameters.
REQ-019 When X_MAX=1 or Y_MAX=1, the design SHALL still visit every pixel exactly once; for X_MAX=Y_MAX=1, DONE SHALL follow a single SCAN cycle.

Reset
REQ-020 Asserting reset low SHALL immediately, without waiting for clk, force IDLE, CounterX=0, CounterY=0 and finished=0.
REQ-021 Reset asserted mid-SCAN or in DONE SHALL abort the pass; after reset is released, a pass SHALL start only when enable is sampled high.
REQ-022 Reset release SHALL be synchronous to clk at the system level; the block SHALL NOT contain a reset synchronizer.

Structure
REQ-023 The FSM state enumeration (IDLE, SCAN, DONE) and the default dimension constants (160, 120) SHALL reside in shared package clear_pkg.
REQ-024 The block SHALL be a single module with no sub-module; the X/Y counters and the FSM SHALL be inline.

Verification
REQ-025 Reset test: hold reset=0 with enable=1 -> CounterX=0, CounterY=0 and finished=0 throughout, with no scanning.
REQ-026 Full pass: release reset, then set enable=1 for 20000 cycles -> X runs 0..159 on each row, Y runs 0..119, 19200 distinct pixels appear in order, finished rises on edge 19200 and holds with counters at (0,0).
REQ-027 Row wrap: at (159,5) the next edge -> (0,6); at (159,119) the next edge -> DONE with finished=1.
REQ-028 Abort: drop enable at (37,42) -> the next edge gives IDLE, (0,0) and finished=0; re-enabling restarts the pass from (0,0).
REQ-029 Mid-pass reset: assert reset at (10,3) -> outputs go to 0 asynchronously; after release with enable=1, a full pass of 19200 pixels completes.
REQ-030 Small geometry: with X_MAX=4 and Y_MAX=2, enabling produces (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1) and finished rises on edge 8.
